// File: rtl/act_pkg.sv
// Shared types and default build constants for the multi-lane activation pipeline.
package act_pkg;

  typedef enum logic [1:0] {
    ACT_BYPASS = 2'd0,
    ACT_RELU   = 2'd1,
    ACT_LEAKY  = 2'd2,
    ACT_CLAMP  = 2'd3
  } act_mode_e;

  localparam int BITWIDTH_DEF   = 32;
  localparam int LANES_DEF      = 4;
  localparam int LEAK_SHIFT_DEF = 3;
  localparam int CNT_W_DEF      = 16;

endpackage

// File: rtl/act_lane.sv
// Combinational activation of one signed element under the selected mode.
module act_lane
  import act_pkg::*;
#(
  parameter int BITWIDTH   = BITWIDTH_DEF,
  parameter int LEAK_SHIFT = LEAK_SHIFT_DEF
) (
  input  logic signed [BITWIDTH-1:0] x,
  input  act_mode_e                  mode,
  input  logic signed [BITWIDTH-1:0] clamp,
  output logic signed [BITWIDTH-1:0] y
);

  // Upper-bound saturation; a negative bound collapses to zero so CLAMP never outputs negatives.
  function automatic logic signed [BITWIDTH-1:0] sat_upper(
    input logic signed [BITWIDTH-1:0] v,
    input logic signed [BITWIDTH-1:0] lim
  );
    logic signed [BITWIDTH-1:0] c;
    c = lim[BITWIDTH-1] ? '0 : lim;
    return (v > c) ? c : v;
  endfunction

  always_comb begin
    y = x;
    case (mode)
      ACT_BYPASS: y = x;
      ACT_RELU:   y = x[BITWIDTH-1] ? '0 : x;
      ACT_LEAKY:  y = x[BITWIDTH-1] ? (x >>> LEAK_SHIFT) : x;
      ACT_CLAMP:  y = x[BITWIDTH-1] ? '0 : sat_upper(x, clamp);
      default:    y = x;
    endcase
  end

endmodule

// File: rtl/act_pipe.sv
// Two-stage, LANES-wide activation unit with valid/ready flow control and a
// per-frame saturating count of negative input elements.
module act_pipe
  import act_pkg::*;
#(
  parameter int BITWIDTH   = BITWIDTH_DEF,
  parameter int LANES      = LANES_DEF,
  parameter int LEAK_SHIFT = LEAK_SHIFT_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cfg_valid,
  input  logic [1:0]                cfg_mode,
  input  logic [BITWIDTH-1:0]       cfg_clamp,
  output logic                      cfg_ready,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [LANES*BITWIDTH-1:0] in_data,
  input  logic                      in_last,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LANES*BITWIDTH-1:0] out_data,
  output logic                      out_last,
  output logic [CNT_W-1:0]          neg_count,
  output logic                      neg_count_valid
);

  localparam int PC_W  = $clog2(LANES + 1);
  localparam int SUM_W = CNT_W + 1;

  function automatic logic [PC_W-1:0] count_neg(input logic [LANES*BITWIDTH-1:0] d);
    logic [PC_W-1:0] n;
    n = '0;
    for (int i = 0; i < LANES; i++) n = n + PC_W'(d[i*BITWIDTH + BITWIDTH-1]);
    return n;
  endfunction

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [PC_W-1:0]  b);
    logic [SUM_W-1:0] s;
    s = {1'b0, a} + SUM_W'(b);
    return s[CNT_W] ? '1 : s[CNT_W-1:0];
  endfunction

  act_mode_e                  mode_q, mode_p1;
  logic signed [BITWIDTH-1:0] clamp_q, clamp_p1;
  logic                       frame_open;
  logic                       vld_p1, last_p1, vld_p2, last_p2;
  logic [LANES*BITWIDTH-1:0]  data_p1, act_p1, data_p2;
  logic [PC_W-1:0]            negs_p1;
  logic [CNT_W-1:0]           run_cnt, neg_count_q;
  logic                       neg_count_valid_q;
  logic                       adv, cfg_fire, in_fire, s1_adv, frame_done;

  // Config only lands on an empty, closed pipeline and steals the input slot that cycle.
  assign adv        = !vld_p2 || out_ready;
  assign cfg_ready  = !vld_p1 && !vld_p2 && !frame_open;
  assign cfg_fire   = cfg_valid && cfg_ready;
  assign in_ready   = adv && !cfg_fire;
  assign in_fire    = in_valid && in_ready;
  assign s1_adv     = adv && vld_p1;
  assign frame_done = vld_p2 && out_ready && last_p2;

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q  <= ACT_RELU;
      clamp_q <= '0;
    end else if (cfg_fire) begin
      mode_q  <= act_mode_e'(cfg_mode);
      clamp_q <= cfg_clamp;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) frame_open <= 1'b0;
    else if (in_fire) frame_open <= !in_last;
  end

  // ---- stage 1: capture beat, config snapshot and sign count ----
  always_ff @(posedge clk) begin
    if (rst) vld_p1 <= 1'b0;
    else if (adv) vld_p1 <= in_fire;
  end

  always_ff @(posedge clk) begin
    if (in_fire) begin
      data_p1  <= in_data;
      last_p1  <= in_last;
      mode_p1  <= mode_q;
      clamp_p1 <= clamp_q;
      negs_p1  <= count_neg(in_data);
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    act_lane #(
      .BITWIDTH  (BITWIDTH),
      .LEAK_SHIFT(LEAK_SHIFT)
    ) u_lane (
      .x    (data_p1[g*BITWIDTH +: BITWIDTH]),
      .mode (mode_p1),
      .clamp(clamp_p1),
      .y    (act_p1[g*BITWIDTH +: BITWIDTH])
    );
  end

  // ---- stage 2: activated result presented downstream ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p2  <= 1'b0;
      data_p2 <= '0;
      last_p2 <= 1'b0;
    end else if (adv) begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        data_p2 <= act_p1;
        last_p2 <= last_p1;
      end
    end
  end

  // A beat entering S2 in the same cycle the frame closes belongs to the next frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      run_cnt           <= '0;
      neg_count_q       <= '0;
      neg_count_valid_q <= 1'b0;
    end else begin
      neg_count_valid_q <= frame_done;
      if (frame_done) begin
        neg_count_q <= run_cnt;
        run_cnt     <= s1_adv ? sat_add('0, negs_p1) : '0;
      end else if (s1_adv) begin
        run_cnt <= sat_add(run_cnt, negs_p1);
      end
    end
  end

  assign out_valid       = vld_p2;
  assign out_data        = data_p2;
  assign out_last        = last_p2;
  assign neg_count       = neg_count_q;
  assign neg_count_valid = neg_count_valid_q;

endmodule

// File: tb/tb_act_pipe.sv
// Scoreboard bench for act_pipe: directed scenarios plus randomized frames
// checked against an arithmetic reference of the activation rules.
module tb_act_pipe;

  localparam int BW = 32;
  localparam int LN = 4;
  localparam int LS = 3;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_valid;
  logic [1:0]    cfg_mode;
  logic [BW-1:0] cfg_clamp;
  logic          cfg_ready;
  logic          in_valid;
  logic          in_ready;
  logic [LN*BW-1:0] in_data;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [LN*BW-1:0] out_data;
  logic          out_last;
  logic [CW-1:0] neg_count;
  logic          neg_count_valid;

  always #5 clk = ~clk;

  act_pipe #(.BITWIDTH(BW), .LANES(LN), .LEAK_SHIFT(LS), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_mode(cfg_mode), .cfg_clamp(cfg_clamp), .cfg_ready(cfg_ready),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .neg_count(neg_count), .neg_count_valid(neg_count_valid)
  );

  typedef struct {
    logic [LN*BW-1:0] data;
    logic             last;
  } beat_t;

  beat_t  exp_q[$];
  int     frame_q[$];
  int     checks = 0;
  int     fails = 0;
  int     model_mode;
  longint model_clamp;
  int     run_negs;
  logic   rand_bp = 1'b0;
  logic   pulse_due = 1'b0;
  int     held_cnt = 0;

  task automatic chk(input string name, input logic [LN*BW-1:0] act, input logic [LN*BW-1:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic note_fail(input string name);
    checks++;
    fails++;
    $display("FAIL %s: bound expired at %0t", name, $time);
  endtask

  function automatic longint ref_act(input longint x, input int m, input longint c);
    longint cc, div;
    cc  = (c < 0) ? 0 : c;
    div = longint'(1) << LS;
    case (m)
      0:       return x;
      1:       return (x < 0) ? 0 : x;
      2:       return (x < 0) ? -((-x + div - 1) / div) : x;
      default: return (x < 0) ? 0 : ((x > cc) ? cc : x);
    endcase
  endfunction

  function automatic logic [LN*BW-1:0] mk4(input int a, input int b, input int c, input int d);
    return {d, c, b, a};
  endfunction

  function automatic logic [BW-1:0] rand_word();
    case ($urandom_range(0, 4))
      0:       return BW'($urandom_range(0, 400)) - BW'(200);
      1:       return 32'h8000_0000;
      2:       return 32'h7fff_ffff;
      default: return BW'($urandom);
    endcase
  endfunction

  function automatic logic [LN*BW-1:0] rand_beat();
    logic [LN*BW-1:0] d;
    for (int i = 0; i < LN; i++) d[i*BW +: BW] = rand_word();
    return d;
  endfunction

  task automatic push_beat(input logic [LN*BW-1:0] d, input logic last);
    beat_t  b;
    longint x, r;
    for (int i = 0; i < LN; i++) begin
      x = longint'($signed(d[i*BW +: BW]));
      r = ref_act(x, model_mode, model_clamp);
      b.data[i*BW +: BW] = r[BW-1:0];
      if (x < 0) run_negs++;
    end
    b.last = last;
    exp_q.push_back(b);
    if (last) begin
      frame_q.push_back((run_negs > CMAX) ? CMAX : run_negs);
      run_negs = 0;
    end
  endtask

  // All main-thread tasks start and end one time unit after a rising edge.
  task automatic wait_accept(input logic [LN*BW-1:0] d, input logic last);
    logic ok;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk); #1;
      if (ok) begin
        push_beat(d, last);
        return;
      end
    end
    note_fail("accept_timeout");
  endtask

  task automatic send(input logic [LN*BW-1:0] d, input logic last);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    wait_accept(d, last);
    in_valid = 1'b0;
  endtask

  task automatic do_cfg(input int m, input int c);
    logic ok;
    cfg_valid = 1'b1;
    cfg_mode  = m[1:0];
    cfg_clamp = c;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      ok = cfg_ready;
      @(posedge clk); #1;
      if (ok) begin
        model_mode  = m;
        model_clamp = longint'(c);
        cfg_valid   = 1'b0;
        return;
      end
    end
    cfg_valid = 1'b0;
    note_fail("cfg_timeout");
  endtask

  task automatic drain();
    for (int t = 0; t < 400; t++) begin
      @(posedge clk); #1;
      if (exp_q.size() == 0 && frame_q.size() == 0) begin
        @(posedge clk); #1;
        @(posedge clk); #1;
        return;
      end
    end
    note_fail("drain_timeout");
  endtask

  task automatic flush_model();
    exp_q.delete();
    frame_q.delete();
    run_negs    = 0;
    model_mode  = 1;
    model_clamp = 0;
  endtask

  always @(posedge clk) begin
    if (rand_bp) begin
      #1 out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: compare whatever the DUT presents against the scoreboard.
  always @(negedge clk) begin
    if (rst) begin
      pulse_due = 1'b0;
      held_cnt  = 0;
    end else begin
      chk("neg_count_valid", neg_count_valid, pulse_due);
      if (pulse_due) begin
        if (frame_q.size() > 0) held_cnt = frame_q.pop_front();
        else note_fail("frame_q_underflow");
      end
      chk("neg_count", neg_count, held_cnt);
      pulse_due = 1'b0;
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("beat_unexpected", out_valid, 1'b0);
        end else begin
          chk("out_data", out_data, exp_q[0].data);
          chk("out_last", out_last, exp_q[0].last);
          if (out_ready) begin
            pulse_due = exp_q[0].last;
            void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; cfg_valid = 1'b0; cfg_mode = '0; cfg_clamp = '0;
    in_valid = 1'b1; in_data = rand_beat(); in_last = 1'b0; out_ready = 1'b1;
    flush_model();

    // Reset with a beat offered throughout.
    repeat (2) @(posedge clk);
    #1 rst = 1'b0; in_valid = 1'b0;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_neg_count", neg_count, '0);
    chk("rst_ncv", neg_count_valid, 1'b0);
    chk("rst_cfg_ready", cfg_ready, 1'b1);

    // Default RELU and two-cycle latency.
    send(mk4(-3, 5, 0, -1), 1'b1);
    chk("lat_not_early", out_valid, 1'b0);
    @(posedge clk); #1;
    chk("lat_2cyc", out_valid, 1'b1);
    drain();

    do_cfg(2, 0);
    send(mk4(-8, -1, -64, 7), 1'b1);
    do_cfg(3, 100);
    send(mk4(150, -5, 42, 100), 1'b1);
    do_cfg(3, -20);
    send(mk4(150, 3, -1, 0), 1'b1);
    drain();

    // Backpressure mid-frame.
    do_cfg(0, 0);
    fork
      begin
        for (int b = 0; b < 6; b++) send(rand_beat(), b == 5);
      end
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          chk("in_ready_stall", in_ready, 1'b0);
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
    join
    drain();

    // Counter saturation: 20 negatives in a 4-bit counter.
    for (int b = 0; b < 5; b++)
      send(mk4(-1 - int'($urandom_range(0, 999)), -7, 32'h8000_0000, -(b + 1)), b == 4);
    drain();

    // Config attempt inside an open frame is dropped.
    do_cfg(1, 0);
    send(mk4(-40, 9, -2, 3), 1'b0);
    cfg_valid = 1'b1; cfg_mode = 2'd2; cfg_clamp = '0;
    @(negedge clk);
    chk("cfg_ready_open", cfg_ready, 1'b0);
    @(posedge clk); #1;
    cfg_valid = 1'b0;
    send(mk4(-16, -24, 11, -1), 1'b0);
    send(mk4(-800, 12, -9, 0), 1'b1);
    drain();

    // Config and beat offered together on an idle pipeline.
    cfg_valid = 1'b1; cfg_mode = 2'd2; cfg_clamp = '0;
    in_valid = 1'b1; in_data = mk4(-80, -9, 33, -1); in_last = 1'b1;
    @(negedge clk);
    chk("collide_in_ready", in_ready, 1'b0);
    chk("collide_cfg_ready", cfg_ready, 1'b1);
    @(posedge clk); #1;
    cfg_valid = 1'b0;
    model_mode = 2; model_clamp = 0;
    wait_accept(in_data, 1'b1);
    in_valid = 1'b0;
    drain();

    // Randomized frames under random backpressure.
    rand_bp = 1'b1;
    for (int f = 0; f < 30; f++) begin
      if ($urandom_range(0, 1) == 1)
        do_cfg(int'($urandom_range(0, 3)), int'($urandom_range(0, 300)) - 100);
      begin
        int nb;
        nb = int'($urandom_range(1, 5));
        for (int b = 0; b < nb; b++) begin
          send(rand_beat(), b == nb - 1);
          if ($urandom_range(0, 2) == 0) begin @(posedge clk); #1; end
        end
      end
    end
    rand_bp = 1'b0;
    @(posedge clk); #1 out_ready = 1'b1;
    drain();

    // Reset mid-frame with beats stalled in flight.
    do_cfg(2, 0);
    out_ready = 1'b0;
    send(mk4(-5, -6, -7, -8), 1'b0);
    send(mk4(-1, 2, -3, 4), 1'b0);
    rst = 1'b1;
    flush_model();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0; out_ready = 1'b1;
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_cfg_ready", cfg_ready, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    send(mk4(-16, 16, -1, 1), 1'b1);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
